// File: rtl/div_pkg.sv
// div_pkg: shared operand width and request/response records for the divide issue stage
package div_pkg;
    localparam int OPW = 4;
    localparam int TAG_MAX = 8;

    typedef struct packed {
        logic [OPW-1:0]     a;
        logic [OPW-1:0]     b;
        logic [TAG_MAX-1:0] tag;
    } div_req_t;

    typedef struct packed {
        logic [OPW-1:0]     q;
        logic               dbz;
        logic [TAG_MAX-1:0] tag;
    } div_rsp_t;
endpackage

// File: rtl/div_req_fifo.sv
// div_req_fifo: circular request buffer with registered count, full and empty
module div_req_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  div_req_t                 wdata,
    output div_req_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    div_req_t      mem [DEPTH];
    logic [AW-1:0] wp, rp;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign rdata = mem[rp];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/div_issue_stage.sv
// div_issue_stage: queues divide requests, feeds the external divider and registers its result
module div_issue_stage
    import div_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [OPW-1:0]           req_a,
    input  logic [OPW-1:0]           req_b,
    input  logic [TAG_W-1:0]         req_tag,
    output logic [OPW-1:0]           div_a,
    output logic [OPW-1:0]           div_b,
    input  logic [OPW-1:0]           div_q,
    input  logic                     div_dbz,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [OPW-1:0]           rsp_q,
    output logic                     rsp_dbz,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [7:0]               dbz_count
);
    div_req_t head;
    div_rsp_t rsp;
    logic     full, empty, push, load;
    logic     unused_tag_hi;

    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign load      = !empty && (!rsp_valid || rsp_ready);

    div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load),
        .wdata ('{a: req_a, b: req_b, tag: TAG_MAX'(req_tag)}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    // Gate the divider inputs so an empty queue never shows stale operands.
    assign div_a = empty ? '0 : head.a;
    assign div_b = empty ? '0 : head.b;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp       <= '0;
            dbz_count <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp       <= '{q: div_q, dbz: div_dbz, tag: head.tag};
            dbz_count <= dbz_count + 8'(div_dbz && dbz_count != 8'hFF);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_q         = rsp.q;
    assign rsp_dbz       = rsp.dbz;
    assign rsp_tag       = rsp.tag[TAG_W-1:0];
    assign unused_tag_hi = ^rsp.tag;
endmodule

// File: tb/tb_div_issue_stage.sv
// tb_div_issue_stage: directed checks of the divide issue stage against a behavioural divider
module tb_div_issue_stage;
    logic       clk = 0;
    logic       rst = 1;
    logic       req_valid = 0;
    logic       req_ready;
    logic [3:0] req_a = 0, req_b = 0;
    logic [2:0] req_tag = 0;
    logic [3:0] div_a, div_b, div_q;
    logic       div_dbz;
    logic       rsp_valid;
    logic       rsp_ready = 0;
    logic [3:0] rsp_q;
    logic       rsp_dbz;
    logic [2:0] rsp_tag;
    logic [2:0] occupancy;
    logic [7:0] dbz_count;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the ALU's combinational divider.
    always_comb begin
        div_dbz = div_b == 4'd0;
        div_q   = div_dbz ? 4'd0 : div_a / div_b;
    end

    div_issue_stage dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_dbz(div_dbz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_dbz(rsp_dbz), .rsp_tag(rsp_tag),
        .occupancy(occupancy), .dbz_count(dbz_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        checks++;
        if ({rsp_valid, occupancy, dbz_count, req_ready} !== {1'b0, 3'd0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: valid=%0b occ=%0d dbz=%0d ready=%0b, want 0 0 0 1",
                     rsp_valid, occupancy, dbz_count, req_ready);
        end
        checks++;
        if ({rsp_q, rsp_dbz, rsp_tag, div_a, div_b} !== 16'd0) begin
            errors++;
            $display("FAIL reset_rsp: q=%0d dbz=%0b tag=%0d div_a=%0d div_b=%0d, want all 0",
                     rsp_q, rsp_dbz, rsp_tag, div_a, div_b);
        end
    endtask

    task automatic test_single();
        rsp_ready = 1;
        req_valid = 1; req_a = 13; req_b = 3; req_tag = 5;
        step();
        req_valid = 0;
        checks++;
        if ({rsp_valid, occupancy, div_a, div_b} !== {1'b0, 3'd1, 4'd13, 4'd3}) begin
            errors++;
            $display("FAIL single_queued: valid=%0b occ=%0d div_a=%0d div_b=%0d, want 0 1 13 3",
                     rsp_valid, occupancy, div_a, div_b);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_q, rsp_dbz, rsp_tag, occupancy} !== {1'b1, 4'd4, 1'b0, 3'd5, 3'd0}) begin
            errors++;
            $display("FAIL single_rsp: valid=%0b q=%0d dbz=%0b tag=%0d occ=%0d, want 1 4 0 5 0",
                     rsp_valid, rsp_q, rsp_dbz, rsp_tag, occupancy);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_q, rsp_tag} !== {1'b0, 4'd4, 3'd5}) begin
            errors++;
            $display("FAIL single_drain: valid=%0b q=%0d tag=%0d, want 0 4 5", rsp_valid, rsp_q, rsp_tag);
        end
    endtask

    task automatic test_dbz();
        rsp_ready = 1;
        req_valid = 1; req_a = 9; req_b = 0; req_tag = 1;
        step();
        req_valid = 0;
        step();
        checks++;
        if ({rsp_valid, rsp_q, rsp_dbz, dbz_count} !== {1'b1, 4'd0, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL dbz_first: valid=%0b q=%0d dbz=%0b count=%0d, want 1 0 1 1",
                     rsp_valid, rsp_q, rsp_dbz, dbz_count);
        end
        req_valid = 1;
        for (int i = 0; i < 300; i++) step();
        req_valid = 0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (dbz_count !== 8'hFF) begin
            errors++;
            $display("FAIL dbz_saturate: count=%0d, want 255", dbz_count);
        end
        req_b = 1;
    endtask

    task automatic test_backpressure();
        logic acc;
        int   k;
        rsp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1; req_a = 4'(15 - i); req_b = 1; req_tag = 3'(i);
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_ready_%0d: ready=%0b, want 1", i, req_ready);
            end
            step();
        end
        req_a = 10; req_tag = 5;
        checks++;
        if ({occupancy, req_ready, rsp_valid, rsp_q, rsp_tag} !== {3'd4, 1'b0, 1'b1, 4'd15, 3'd0}) begin
            errors++;
            $display("FAIL bp_full: occ=%0d ready=%0b valid=%0b q=%0d tag=%0d, want 4 0 1 15 0",
                     occupancy, req_ready, rsp_valid, rsp_q, rsp_tag);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if ({occupancy, req_ready, rsp_valid, rsp_q, rsp_tag} !== {3'd4, 1'b0, 1'b1, 4'd15, 3'd0}) begin
            errors++;
            $display("FAIL bp_hold: occ=%0d ready=%0b valid=%0b q=%0d tag=%0d, want 4 0 1 15 0",
                     occupancy, req_ready, rsp_valid, rsp_q, rsp_tag);
        end
        rsp_ready = 1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_comb: ready=%0b, want 0", req_ready);
        end
        k = 0;
        for (int c = 0; c < 30 && k < 6; c++) begin
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (rsp_q !== 4'(15 - k) || rsp_tag !== 3'(k)) begin
                    errors++;
                    $display("FAIL bp_order_%0d: q=%0d tag=%0d, want %0d %0d", k, rsp_q, rsp_tag, 15 - k, k);
                end
                k++;
            end
            acc = req_valid && req_ready;
            step();
            if (acc) req_valid = 0;
            if (c == 0) begin
                checks++;
                if ({occupancy, req_ready} !== {3'd3, 1'b1}) begin
                    errors++;
                    $display("FAIL bp_after_pop: occ=%0d ready=%0b, want 3 1", occupancy, req_ready);
                end
            end
        end
        checks++;
        if (k !== 6) begin
            errors++;
            $display("FAIL bp_count: responses=%0d, want 6", k);
        end
        step();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1; req_a = 4'(8 + i); req_b = 4'(1 + i % 3); req_tag = 3'(i);
            step();
            checks++;
            if (occupancy !== 3'd1) begin
                errors++;
                $display("FAIL stream_occ_%0d: occ=%0d, want 1", i, occupancy);
            end
            if (i > 0) begin
                checks++;
                if ({rsp_valid, rsp_q, rsp_tag} !== {1'b1, 4'((7 + i) / (1 + (i - 1) % 3)), 3'(i - 1)}) begin
                    errors++;
                    $display("FAIL stream_rsp_%0d: valid=%0b q=%0d tag=%0d, want 1 %0d %0d",
                             i, rsp_valid, rsp_q, rsp_tag, (7 + i) / (1 + (i - 1) % 3), i - 1);
                end
            end
        end
        req_valid = 0;
        step();
        checks++;
        if ({rsp_valid, rsp_q, rsp_tag, occupancy} !== {1'b1, 4'd7, 3'd7, 3'd0}) begin
            errors++;
            $display("FAIL stream_last: valid=%0b q=%0d tag=%0d occ=%0d, want 1 7 7 0",
                     rsp_valid, rsp_q, rsp_tag, occupancy);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_idle: valid=%0b, want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic stale;
        rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_a = 4'(6 + i); req_b = 0; req_tag = 3'(i);
            step();
        end
        req_valid = 0;
        checks++;
        if ({occupancy, rsp_valid} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL mid_setup: occ=%0d valid=%0b, want 3 1", occupancy, rsp_valid);
        end
        rst = 1;
        step();
        rst = 0;
        checks++;
        if ({rsp_valid, occupancy, dbz_count, req_ready, rsp_q, rsp_dbz, rsp_tag} !==
            {1'b0, 3'd0, 8'd0, 1'b1, 4'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL mid_reset: valid=%0b occ=%0d dbz=%0d ready=%0b q=%0d, want 0 0 0 1 0",
                     rsp_valid, occupancy, dbz_count, req_ready, rsp_q);
        end
        rsp_ready = 1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            stale |= rsp_valid;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: rsp_valid seen=%0b, want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dbz();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_issue_stage.md
# div_issue_stage

Sequential front end for the combinational 4-bit integer divider in the Int ALU. It accepts divide requests over a valid/ready handshake and buffers them in a small FIFO. It presents the head request's operands to the divider and captures the divider's quotient and divide-by-zero flag into a registered, back-pressurable response slot. It also keeps a saturating count of divide-by-zero events for status readout.

## Interface
- DEPTH, 4, request FIFO entries; power of two, ≥2
- TAG_W, 3, width of the opaque request tag returned with each response
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  stage can accept a request this cycle
- req_a  in  4  dividend
- req_b  in  4  divisor
- req_tag  in  TAG_W  request tag
- div_a  out  4  dividend to divider (combinational)
- div_b  out  4  divisor to divider (combinational)
- div_q  in  4  quotient from divider
- div_dbz  in  1  divide-by-zero flag from divider
- rsp_valid  out  1  response slot holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_q  out  4  registered quotient
- rsp_dbz  out  1  registered divide-by-zero flag
- rsp_tag  out  TAG_W  tag of the request that produced the response
- occupancy  out  $clog2(DEPTH)+1  FIFO entries currently held
- dbz_count  out  8  saturating count of divide-by-zero responses loaded

## Operation
- Push: req_valid && req_ready writes {a,b,tag} at the write pointer. req_ready = (occupancy < DEPTH). It depends only on registered state, not on the same-cycle pop.
- Divider drive: div_a/div_b = head entry when occupancy > 0, else 4'h0.
- Load condition: occupancy > 0 && (!rsp_valid || rsp_ready). On load:
  - pop the head;
  - register rsp_q ← div_q, rsp_dbz ← div_dbz, rsp_tag ← head tag;
  - set rsp_valid ← 1.
- Drain: rsp_valid && rsp_ready with no load clears rsp_valid. rsp_q, rsp_dbz and rsp_tag hold their last values.
- Hold: while rsp_valid && !rsp_ready, all rsp_* outputs are stable.
- Simultaneous push and pop leaves occupancy unchanged. Pointers wrap modulo DEPTH.
- dbz_count increments by 1 on each load with div_dbz = 1 and saturates at 8'hFF.
- Ordering is strictly FIFO. Tags are passed through unchanged and are not checked.
- Reset (any cycle, including mid-stream) has the following effects:
  - queued entries and any pending response are discarded;
  - pointers, occupancy, rsp_valid, rsp_q, rsp_dbz, rsp_tag and dbz_count are all set to 0;
  - req_ready is 1 in the first cycle after reset.

## Timing
- Latency: request accepted at edge N gives rsp_valid high after edge N+1, i.e. 2 cycles minimum.
- Throughput: 1 request/cycle sustained when rsp_ready is held high.
- The combinational path from the FIFO head through the external divider to the rsp registers is the critical path. There is no combinational path from req_* or rsp_ready to req_ready.
- Full: with occupancy = DEPTH, req_ready = 0 even if a pop occurs the same cycle. It rises the cycle after the pop.
- Empty: no load occurs. rsp_valid drops after the pending response drains.

## Structure
- Shared package div_pkg holds:
  - OPW = 4;
  - typedef div_req_t {a, b, tag};
  - typedef div_rsp_t {q, dbz, tag}.
- One sub-module, div_req_fifo: parameterised DEPTH, synchronous-reset circular buffer with push/pop/full/empty/count.
- The top level holds the response slot and dbz_count, and connects div_a/div_b/div_q/div_dbz to the existing combinational divider in the ALU.

## Test plan
- Single request, after reset: a=13, b=3, tag=5, rsp_ready=1 -> rsp_valid 2 cycles after acceptance; rsp_q=4, rsp_dbz=0, rsp_tag=5; occupancy returns to 0.
- Divide by zero: a=9, b=0 -> rsp_q=0, rsp_dbz=1, dbz_count 0->1; 300 such requests -> dbz_count saturates at 255.
- Back-pressure and full:
  - stimulus: rsp_ready=0, push 6 requests (15/1 … 10/1);
  - response: first result held stable; occupancy reaches 4; req_ready=0;
  - release: raising rsp_ready drains quotients 15,14,13,12,11,10 in order with matching tags.
- Streaming: back-to-back valid requests with rsp_ready=1 -> one response per cycle, no bubbles, occupancy ≤ 1.
- Reset mid-operation: 3 queued entries plus a pending response, rst for 1 cycle -> next cycle rsp_valid=0, occupancy=0, dbz_count=0, req_ready=1; no stale response ever appears afterwards.
